// File: rtl/telem_frame_loader_if.sv
// Byte-stream input and frame write/status outputs of telem_frame_loader.
// master = byte source / write consumer side, slave = the loader itself.
interface telem_frame_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
    logic        err_pulse;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, frame_cnt, err_cnt, err_pulse
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, frame_cnt, err_cnt, err_pulse
    );
endinterface

// File: rtl/telem_frame_loader.sv
// Parses SYNC/ADDR/DATA/CHK byte frames into one-cycle coordinate-register writes.
// Define TELEM_CHECKSUM_EN to reject frames whose CHK != SYNC ^ ADDR ^ DATA.
module telem_frame_loader #(
    parameter int         NUM_TARGETS = 32,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    telem_frame_loader_if.slave  bus
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [8:0]    NUM_TGT_W = 9'(NUM_TARGETS);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_COMMIT
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          in_ready_q, in_ready_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          err_pulse_q, err_pulse_d;

    logic accept;
    logic in_frame;
    logic range_bad;
    logic chk_bad;
    logic bad_evt;

    assign accept    = bus.in_valid && in_ready_q;
    assign in_frame  = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CHK);
    assign range_bad = {1'b0, addr_q} >= NUM_TGT_W;

`ifdef TELEM_CHECKSUM_EN
    assign chk_bad = bus.in_data != (SYNC_BYTE ^ addr_q ^ data_q);
`else
    assign chk_bad = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        tmo_d       = '0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        bad_evt     = 1'b0;

        unique case (state_q)
            S_HUNT: begin
                if (accept && bus.in_data == SYNC_BYTE) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (accept) begin
                    addr_d  = bus.in_data;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    data_d  = bus.in_data;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (accept) begin
                    if (range_bad || chk_bad) begin
                        bad_evt = 1'b1;
                        state_d = S_HUNT;
                    end else begin
                        wr_en_d     = 1'b1;
                        wr_addr_d   = addr_q;
                        wr_data_d   = data_q;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_HUNT;
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        // An accepted byte always clears the idle count, so it beats a timeout on the same edge.
        if (in_frame && !accept) begin
            if (tmo_q == TMO_LAST) begin
                bad_evt = 1'b1;
                state_d = S_HUNT;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (bad_evt) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end

        in_ready_d = (state_d != S_COMMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HUNT;
            addr_q      <= '0;
            data_q      <= '0;
            tmo_q       <= '0;
            in_ready_q  <= 1'b1;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            tmo_q       <= tmo_d;
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.err_pulse = err_pulse_q;

endmodule

// File: tb/tb_telem_frame_loader.sv
// Self-checking bench for telem_frame_loader: directed vector table, hand-written
// timeout/reset/saturation sequences, and random frames against a queue-based model.
module tb_telem_frame_loader;

    localparam int         NUM_TARGETS = 32;
    localparam logic [7:0] SYNC        = 8'hA5;
    localparam int         TIMEOUT     = 16;

    logic clk = 1'b0;
    logic rst;

    telem_frame_loader_if bus();

    telem_frame_loader #(
        .NUM_TARGETS (NUM_TARGETS),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a frame is the list of bytes collected since SYNC.
    logic [7:0]  m_frm[$];
    int          m_idle;
    bit          m_commit;
    logic        m_ready, m_wr_en, m_ep;
    logic [7:0]  m_wa, m_wd, m_ec;
    logic [15:0] m_fc;

    task automatic model_reset();
        m_frm.delete();
        m_idle   = 0;
        m_commit = 1'b0;
        m_ready  = 1'b1;
        m_wr_en  = 1'b0;
        m_ep     = 1'b0;
        m_wa     = 8'h00;
        m_wd     = 8'h00;
        m_ec     = 8'h00;
        m_fc     = 16'h0000;
    endtask

    task automatic model_err();
        m_ep = 1'b1;
        if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d);
        bit acc;
        bit chk_ok;
        acc     = v && m_ready;
        m_wr_en = 1'b0;
        m_ep    = 1'b0;
        if (m_commit) begin
            m_commit = 1'b0;
        end else if (acc) begin
            m_idle = 0;
            if (m_frm.size() == 0) begin
                if (d == SYNC) m_frm.push_back(d);
            end else if (m_frm.size() < 3) begin
                m_frm.push_back(d);
            end else begin
`ifdef TELEM_CHECKSUM_EN
                chk_ok = (d == (SYNC ^ m_frm[1] ^ m_frm[2]));
`else
                chk_ok = 1'b1;
`endif
                if (int'(m_frm[1]) < NUM_TARGETS && chk_ok) begin
                    m_wr_en  = 1'b1;
                    m_wa     = m_frm[1];
                    m_wd     = m_frm[2];
                    m_fc     = m_fc + 16'd1;
                    m_commit = 1'b1;
                end else begin
                    model_err();
                end
                m_frm.delete();
            end
        end else if (m_frm.size() != 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                model_err();
                m_frm.delete();
                m_idle = 0;
            end
        end
        m_ready = !m_commit;
    endtask

    function automatic logic [42:0] dut_vec();
        return {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
                bus.frame_cnt, bus.err_cnt, bus.err_pulse};
    endfunction

    function automatic logic [42:0] model_vec();
        return {m_ready, m_wr_en, m_wa, m_wd, m_fc, m_ec, m_ep};
    endfunction

    bit last_acc;

    // Drive one cycle of input, advance past the edge, compare against the model.
    task automatic step(input bit v, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        last_acc     = v && bus.in_ready;
        model_edge(v, d);
        @(posedge clk);
        #1;
        check("cycle_vs_model", 64'(dut_vec()), 64'(model_vec()));
    endtask

    task automatic send_byte(input logic [7:0] d);
        int tries;
        tries = 0;
        do begin
            step(1'b1, d);
            tries++;
        end while (!last_acc && tries < 4);
        check("byte_accepted", 64'(last_acc), 64'(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [7:0]  wa;
        logic [7:0]  wd;
        logic [15:0] fc;
        logic [7:0]  ec;
        logic        ep;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit v, input logic [7:0] d, input logic rdy, input logic we,
                       input logic [7:0] wa, input logic [7:0] wd, input logic [15:0] fc,
                       input logic [7:0] ec, input logic ep);
        vec_t r;
        r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.wa = wa; r.wd = wd;
        r.fc = fc; r.ec = ec; r.ep = ep;
        tbl.push_back(r);
    endtask

    initial begin
        logic [7:0] a, dv, c;

        // Good frame, noise + frame, range error, checksum-dependent frame.
        add(1, 8'hA5, 1, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h03, 1, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h5C, 1, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'hFA, 0, 1, 8'h03, 8'h5C, 1, 0, 0);
        add(1, 8'h00, 1, 0, 8'h03, 8'h5C, 1, 0, 0);
        add(1, 8'h00, 1, 0, 8'h03, 8'h5C, 1, 0, 0);
        add(1, 8'hFF, 1, 0, 8'h03, 8'h5C, 1, 0, 0);
        add(1, 8'hA5, 1, 0, 8'h03, 8'h5C, 1, 0, 0);
        add(1, 8'h1F, 1, 0, 8'h03, 8'h5C, 1, 0, 0);
        add(1, 8'h80, 1, 0, 8'h03, 8'h5C, 1, 0, 0);
        add(1, 8'h3A, 0, 1, 8'h1F, 8'h80, 2, 0, 0);
        add(0, 8'h00, 1, 0, 8'h1F, 8'h80, 2, 0, 0);
        add(1, 8'hA5, 1, 0, 8'h1F, 8'h80, 2, 0, 0);
        add(1, 8'h20, 1, 0, 8'h1F, 8'h80, 2, 0, 0);
        add(1, 8'h11, 1, 0, 8'h1F, 8'h80, 2, 0, 0);
        add(1, 8'h94, 1, 0, 8'h1F, 8'h80, 2, 1, 1);
        add(0, 8'h00, 1, 0, 8'h1F, 8'h80, 2, 1, 0);
        add(1, 8'hA5, 1, 0, 8'h1F, 8'h80, 2, 1, 0);
        add(1, 8'h03, 1, 0, 8'h1F, 8'h80, 2, 1, 0);
        add(1, 8'h5C, 1, 0, 8'h1F, 8'h80, 2, 1, 0);
`ifdef TELEM_CHECKSUM_EN
        add(1, 8'h00, 1, 0, 8'h1F, 8'h80, 2, 2, 1);
        add(0, 8'h00, 1, 0, 8'h1F, 8'h80, 2, 2, 0);
`else
        add(1, 8'h00, 0, 1, 8'h03, 8'h5C, 3, 1, 0);
        add(0, 8'h00, 1, 0, 8'h03, 8'h5C, 3, 1, 0);
`endif

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", 64'(dut_vec()), 64'({1'b1, 42'b0}));
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d);
            check($sformatf("vec[%0d]", i), 64'(dut_vec()),
                  64'({tbl[i].rdy, tbl[i].we, tbl[i].wa, tbl[i].wd,
                       tbl[i].fc, tbl[i].ec, tbl[i].ep}));
        end

        // Timeout: error pulse lands on the 16th idle edge, not before.
        send_byte(8'hA5);
        send_byte(8'h07);
        for (int i = 0; i < TIMEOUT; i++) begin
            step(1'b0, 8'h00);
            check($sformatf("tmo_pulse[%0d]", i), 64'(bus.err_pulse), 64'(i == TIMEOUT - 1));
        end
        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'h01);
        send_byte(8'hA3);
        check("tmo_recover_write", 64'({bus.wr_en, bus.wr_addr, bus.wr_data}), 64'({1'b1, 8'h07, 8'h01}));
        idle(1);

        // A byte arriving on the edge the timeout would fire wins.
        send_byte(8'hA5);
        send_byte(8'h07);
        idle(TIMEOUT - 1);
        send_byte(8'h01);
        check("byte_beats_timeout", 64'(bus.err_pulse), 64'(0));
        idle(TIMEOUT - 1);
        send_byte(8'hA3);
        check("late_frame_write", 64'({bus.wr_en, bus.wr_data}), 64'({1'b1, 8'h01}));

        // Async reset mid-frame, then mid-COMMIT: outputs clear without waiting for an edge.
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h5C);
        #3 rst = 1'b1;
        #1;
        check("async_reset_midframe", 64'(dut_vec()), 64'({1'b1, 42'b0}));
        model_reset();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h5C);
        send_byte(8'hFA);
        check("post_reset_commit", 64'({bus.wr_en, bus.frame_cnt}), 64'({1'b1, 16'd1}));
        #3 rst = 1'b1;
        #1;
        check("reset_drops_wr_en", 64'(dut_vec()), 64'({1'b1, 42'b0}));
        model_reset();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Random frames with noise, corrupt checksums, bad addresses and long gaps.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                int g = $urandom_range(0, 20);
                for (int j = 0; j < g; j++) step(1'b0, 8'($urandom));
            end
            if ($urandom_range(0, 5) == 0) send_byte(8'($urandom));
            a  = 8'($urandom_range(0, 40));
            dv = 8'($urandom);
            c  = SYNC ^ a ^ dv;
            if ($urandom_range(0, 7) == 0) c = c ^ 8'h5A;
            send_byte(SYNC);
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 9) == 0) idle($urandom_range(10, 18));
                send_byte(b == 0 ? a : (b == 1 ? dv : c));
            end
        end
        idle(2);

        // Drive err_cnt into saturation; pulses continue at 8'hFF.
        for (int k = 0; k < 260; k++) begin
            send_byte(8'hA5);
            send_byte(8'h20);
            send_byte(8'h11);
            send_byte(8'h94);
        end
        check("err_cnt_saturated", 64'(bus.err_cnt), 64'(8'hFF));
        check("err_pulse_at_sat", 64'(bus.err_pulse), 64'(1));
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
